// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// with a fixed per-class latency and handles zero-latency MTHI/MTLO.
module mdu #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    logic [CNT_W-1:0] cnt;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    logic             is_md_c;
    logic [31:0]      abs_a_c;
    logic [31:0]      abs_b_c;
    logic [31:0]      div_n_c;
    logic [31:0]      div_d_c;
    logic [31:0]      quo_c;
    logic [31:0]      rem_c;
    logic [63:0]      mul_s_c;
    logic [63:0]      mul_u_c;
    logic [31:0]      res_hi_c;
    logic [31:0]      res_lo_c;

    assign is_md_c = (op == OP_MULT) || (op == OP_MULTU) ||
                     (op == OP_DIV)  || (op == OP_DIVU);
    assign stall   = busy | (start & is_md_c);

    // One shared unsigned divider; signed DIV runs on magnitudes and fixes signs after.
    always_comb begin
        abs_a_c  = A[31] ? 32'(-A) : A;
        abs_b_c  = B[31] ? 32'(-B) : B;
        div_n_c  = (op == OP_DIV) ? abs_a_c : A;
        div_d_c  = (op == OP_DIV) ? abs_b_c : B;
        quo_c    = (div_d_c == 32'd0) ? 32'd0 : div_n_c / div_d_c;
        rem_c    = (div_d_c == 32'd0) ? 32'd0 : div_n_c % div_d_c;
        mul_s_c  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        mul_u_c  = {32'd0, A} * {32'd0, B};
        res_hi_c = 32'd0;
        res_lo_c = 32'd0;
        case (op_e'(op))
            OP_MULT: begin
                res_hi_c = mul_s_c[63:32];
                res_lo_c = mul_s_c[31:0];
            end
            OP_MULTU: begin
                res_hi_c = mul_u_c[63:32];
                res_lo_c = mul_u_c[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (B == 32'd0) begin
                    res_hi_c = A;
                    res_lo_c = 32'hFFFF_FFFF;
                end else if (op == OP_DIV) begin
                    // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0
                    res_lo_c = (A[31] ^ B[31]) ? 32'(-quo_c) : quo_c;
                    res_hi_c = A[31] ? 32'(-rem_c) : rem_c;
                end else begin
                    res_lo_c = quo_c;
                    res_hi_c = rem_c;
                end
            end
            default: begin
                res_hi_c = 32'd0;
                res_lo_c = 32'd0;
            end
        endcase
    end

    // Result is captured at acceptance and committed when the counter expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI     <= 32'd0;
            LO     <= 32'd0;
            busy   <= 1'b0;
            cnt    <= '0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
        end else if (busy) begin
            if (cnt == CNT_W'(1)) begin
                HI   <= res_hi;
                LO   <= res_lo;
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (start) begin
            case (op_e'(op))
                OP_MULT, OP_MULTU: begin
                    res_hi <= res_hi_c;
                    res_lo <= res_lo_c;
                    cnt    <= CNT_W'(MUL_LAT);
                    busy   <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    res_hi <= res_hi_c;
                    res_lo <= res_lo_c;
                    cnt    <= CNT_W'(DIV_LAT);
                    busy   <= 1'b1;
                end
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule
